// File: rtl/system_pkg.sv
// Shared constants for the system datapath: word/address widths, IR field
// positions and ALU opcode encodings.
package system_pkg;

  localparam int WORD_W  = 32;
  localparam int MEM_AW  = 9;
  localparam int REG_CNT = 16;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;
  localparam int C_MSB   = 18;
  localparam int C_W     = 19;
  localparam int CON_MSB = 20;
  localparam int CON_LSB = 19;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_LD   = 5'b00001;
  localparam logic [4:0] OP_LDI  = 5'b00010;
  localparam logic [4:0] OP_ST   = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

endpackage

// File: rtl/system_alu.sv
// Combinational ALU producing the 64-bit Z value from Y and the bus.
// Multiply/divide exist only when SYSTEM_MULDIV_EN is defined.
module system_alu
  import system_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic [W-1:0]   y,
  input  logic [W-1:0]   b,
  input  logic [4:0]     op,
  input  logic           inc_pc,
  output logic [2*W-1:0] z
);

  localparam int SW = $clog2(W);
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [SW-1:0]  sh;
  logic [2*W-1:0] y_rot;
  logic [2*W-1:0] ror_full;
  logic [2*W-1:0] rol_full;

  assign sh       = b[SW-1:0];
  assign y_rot    = {y, y};
  assign ror_full = y_rot >> sh;
  assign rol_full = y_rot << sh;

`ifdef SYSTEM_MULDIV_EN
  logic signed [2*W-1:0] prod;
  logic signed [W-1:0]   quo;
  logic signed [W-1:0]   rem;

  assign prod = $signed({{W{y[W-1]}}, y}) * $signed({{W{b[W-1]}}, b});
  // Guarded so a zero divisor never reaches the divider.
  assign quo  = (b == '0) ? '0 : $signed(y) / $signed(b);
  assign rem  = (b == '0) ? '0 : $signed(y) % $signed(b);
`endif

  always_comb begin
    z = '0;
    if (inc_pc) begin
      z[W-1:0] = b + ONE;
    end else begin
      unique case (op)
        OP_ADD, OP_LD, OP_LDI, OP_ST, OP_ADDI: z[W-1:0] = y + b;
        OP_SUB:           z[W-1:0] = y - b;
        OP_AND, OP_ANDI:  z[W-1:0] = y & b;
        OP_OR, OP_ORI:    z[W-1:0] = y | b;
        OP_SHR:           z[W-1:0] = y >> sh;
        OP_SHRA:          z[W-1:0] = $signed(y) >>> sh;
        OP_SHL:           z[W-1:0] = y << sh;
        OP_ROR:           z[W-1:0] = ror_full[W-1:0];
        OP_ROL:           z[W-1:0] = rol_full[2*W-1:W];
`ifdef SYSTEM_MULDIV_EN
        OP_MUL:           z = prod;
        OP_DIV:           z = {rem, quo};
`else
        OP_MUL, OP_DIV:   z = '0;
`endif
        OP_NEG:           z[W-1:0] = -b;
        OP_NOT:           z[W-1:0] = ~b;
        default:          z[W-1:0] = b;
      endcase
    end
  end

endmodule

// File: rtl/system.sv
// Bus-based datapath: register file, special registers, CON logic, ALU and a
// 512-word memory with a preload path. Optional mul/div: SYSTEM_MULDIV_EN.
module system
  import system_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  Clock,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] inport_data,
  output logic [DATA_WIDTH-1:0] outport_data,
  input  logic                  HIout,
  input  logic                  LOout,
  input  logic                  Zhi_out,
  input  logic                  Zlo_out,
  input  logic                  PCout,
  input  logic                  MDRout,
  input  logic                  Inport_out,
  input  logic                  Cout,
  input  logic                  BAout,
  input  logic                  Rout,
  input  logic                  MARin,
  input  logic                  Zin,
  input  logic                  PCin,
  input  logic                  MDRin,
  input  logic                  IRin,
  input  logic                  Yin,
  input  logic                  HIin,
  input  logic                  LOin,
  input  logic                  CONin,
  input  logic                  Rin,
  input  logic                  outport_in,
  input  logic                  inport_data_ready,
  input  logic [4:0]            opcode,
  input  logic                  IncPC,
  input  logic                  Gra,
  input  logic                  Grb,
  input  logic                  Grc,
  input  logic                  Mem_Read,
  input  logic                  Mem_Write,
  input  logic                  Mem_enable512x32,
  output logic                  con_ff_bit,
  output logic [DATA_WIDTH-1:0] Mem_to_datapath_out,
  output logic [DATA_WIDTH-1:0] Mem_data_to_chip_out,
  output logic [ADDR_WIDTH-1:0] MAR_address_out,
  input  logic                  mem_overide,
  input  logic [ADDR_WIDTH-1:0] overide_address,
  input  logic [DATA_WIDTH-1:0] overide_data_in
);

  logic [DATA_WIDTH-1:0]   r [REG_CNT];
  logic [DATA_WIDTH-1:0]   pc, ir, mdr, y_q, zhi, zlo, hi, lo, inport, outport;
  logic [ADDR_WIDTH-1:0]   mar;
  logic                    con;
  logic [DATA_WIDTH-1:0]   bus;
  logic [DATA_WIDTH-1:0]   c_sext;
  logic [3:0]              rsel;
  logic                    con_d;
  logic [2*DATA_WIDTH-1:0] alu_z;
  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];
  logic                    mem_clk;
  logic                    unused_ir_op;

  assign unused_ir_op = ^ir[OP_MSB:OP_LSB];

  assign rsel   = ({4{Gra}} & ir[RA_MSB:RA_LSB]) |
                  ({4{Grb}} & ir[RB_MSB:RB_LSB]) |
                  ({4{Grc}} & ir[RC_MSB:RC_LSB]);
  assign c_sext = {{(DATA_WIDTH-C_W){ir[C_MSB]}}, ir[C_MSB:0]};

  always_comb begin
    bus = '0;
    if      (HIout)             bus = hi;
    else if (LOout)             bus = lo;
    else if (Zhi_out)           bus = zhi;
    else if (Zlo_out)           bus = zlo;
    else if (PCout)             bus = pc;
    else if (MDRout)            bus = mdr;
    else if (Inport_out)        bus = inport;
    else if (Cout)              bus = c_sext;
    else if (Rout)              bus = r[rsel];
    else if (BAout)             bus = (rsel == 4'd0) ? '0 : r[rsel];
    else if (inport_data_ready) bus = inport_data;
  end

  always_comb begin
    case (ir[CON_MSB:CON_LSB])
      2'b00:   con_d = (bus == '0);
      2'b01:   con_d = (bus != '0);
      2'b10:   con_d = ~bus[DATA_WIDTH-1];
      default: con_d = bus[DATA_WIDTH-1];
    endcase
  end

  system_alu #(.W(DATA_WIDTH)) u_alu (
    .y      (y_q),
    .b      (bus),
    .op     (opcode),
    .inc_pc (IncPC),
    .z      (alu_z)
  );

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < REG_CNT; i++) r[i] <= '0;
      pc <= '0; ir <= '0; mar <= '0; mdr <= '0; y_q <= '0;
      zhi <= '0; zlo <= '0; hi <= '0; lo <= '0;
      inport <= '0; outport <= '0; con <= 1'b0;
    end else begin
      if (Rin)               r[rsel] <= bus;
      if (PCin)              pc <= bus;
      if (IRin)              ir <= bus;
      if (MARin)             mar <= bus[ADDR_WIDTH-1:0];
      if (MDRin)             mdr <= Mem_Read ? Mem_to_datapath_out : bus;
      if (Yin)               y_q <= bus;
      if (Zin)               {zhi, zlo} <= alu_z;
      if (HIin)              hi <= bus;
      if (LOin)              lo <= bus;
      if (inport_data_ready) inport <= inport_data;
      if (outport_in)        outport <= bus;
      if (CONin)             con <= con_d;
    end
  end

  // While preloading, the memory is clocked by the enable strobe instead of
  // Clock; mem_overide should only change while Mem_enable512x32 is low.
  assign mem_clk = mem_overide ? Mem_enable512x32 : Clock;

  always_ff @(posedge mem_clk) begin
    if (mem_overide)
      mem[overide_address] <= overide_data_in;
    else if (Mem_Write && Mem_enable512x32)
      mem[mar] <= mdr;
  end

  assign Mem_to_datapath_out  = (Mem_Read && Mem_enable512x32 && !clear) ? mem[mar] : '0;
  assign Mem_data_to_chip_out = mdr;
  assign MAR_address_out      = mar;
  assign outport_data         = outport;
  assign con_ff_bit           = con;

endmodule

// File: tb/tb_system.sv
// Self-checking bench for system: directed fetch/IO/CON/memory sequences,
// a table of ALU vectors and randomized ALU operations against a model.
module tb_system;

  logic        Clock = 1'b0;
  logic        clear;
  logic [31:0] inport_data, outport_data;
  logic        HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout, BAout, Rout;
  logic        MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, Rin, outport_in;
  logic        inport_data_ready;
  logic [4:0]  opcode;
  logic        IncPC, Gra, Grb, Grc, Mem_Read, Mem_Write, Mem_enable512x32;
  logic        con_ff_bit;
  logic [31:0] Mem_to_datapath_out, Mem_data_to_chip_out;
  logic [8:0]  MAR_address_out;
  logic        mem_overide;
  logic [8:0]  overide_address;
  logic [31:0] overide_data_in;

  int n_pass = 0;
  int n_total = 0;

  always #5 Clock = ~Clock;

  system dut (
    .Clock(Clock), .clear(clear), .inport_data(inport_data), .outport_data(outport_data),
    .HIout(HIout), .LOout(LOout), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out), .PCout(PCout),
    .MDRout(MDRout), .Inport_out(Inport_out), .Cout(Cout), .BAout(BAout), .Rout(Rout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .CONin(CONin), .Rin(Rin), .outport_in(outport_in),
    .inport_data_ready(inport_data_ready), .opcode(opcode), .IncPC(IncPC),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
    .Mem_enable512x32(Mem_enable512x32), .con_ff_bit(con_ff_bit),
    .Mem_to_datapath_out(Mem_to_datapath_out), .Mem_data_to_chip_out(Mem_data_to_chip_out),
    .MAR_address_out(MAR_address_out), .mem_overide(mem_overide),
    .overide_address(overide_address), .overide_data_in(overide_data_in)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } alu_vec_t;

  alu_vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
  endtask

  task automatic idle();
    {HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout, BAout, Rout} = '0;
    {MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, Rin, outport_in} = '0;
    {inport_data_ready, IncPC, Gra, Grb, Grc, Mem_Read, Mem_Write, Mem_enable512x32} = '0;
    opcode = '0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic drive_bus(input logic [31:0] v);
    inport_data = v;
    inport_data_ready = 1'b1;
  endtask

  task automatic load_ir(input logic [31:0] v);
    drive_bus(v); IRin = 1'b1; tick();
  endtask

  task automatic preload(input logic [8:0] addr, input logic [31:0] data);
    overide_address = addr;
    overide_data_in = data;
    #2 Mem_enable512x32 = 1'b1;
    #2 Mem_enable512x32 = 1'b0;
    #1;
  endtask

  task automatic fetch_t0();
    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
  endtask

  task automatic fetch_t1();
    Zlo_out = 1'b1; PCin = 1'b1; Mem_Read = 1'b1; Mem_enable512x32 = 1'b1; MDRin = 1'b1;
  endtask

  task automatic alu_run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo);
    drive_bus(a); Yin = 1'b1; tick();
    drive_bus(b); opcode = op; Zin = 1'b1; tick();
    Zlo_out = 1'b1; outport_in = 1'b1; tick(); lo = outport_data;
    Zhi_out = 1'b1; outport_in = 1'b1; tick(); hi = outport_data;
  endtask

  // Reference: each result computed with 64-bit integer arithmetic.
  function automatic logic [63:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint pow = longint'(64'd1 << b[4:0]);
    int n = int'(b[4:0]);
    logic [63:0] t;
    logic [31:0] r = '0;
    case (op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd12: r = 32'(ua + longint'({32'd0, b}));
      5'd4:         r = 32'(sa - sb);
      5'd5, 5'd13:  r = a & b;
      5'd6, 5'd14:  r = a | b;
      5'd7:         r = 32'(ua / pow);
      5'd8:         r = 32'(sa >>> n);
      5'd9:         r = 32'(ua * pow);
      5'd10: for (int i = 0; i < 32; i++) r[i] = a[(i + n) % 32];
      5'd11: for (int i = 0; i < 32; i++) r[(i + n) % 32] = a[i];
      5'd15: begin
`ifdef SYSTEM_MULDIV_EN
        t = 64'(sa * sb);
        return t;
`else
        return 64'd0;
`endif
      end
      5'd16: begin
`ifdef SYSTEM_MULDIV_EN
        if (sb == 0) return 64'd0;
        t = {32'(sa % sb), 32'(sa / sb)};
        return t;
`else
        return 64'd0;
`endif
      end
      5'd17:        r = 32'(-sb);
      5'd18:        r = ~b;
      default:      r = b;
    endcase
    return {32'd0, r};
  endfunction

  initial begin
    logic [31:0] hi, lo;
    logic [63:0] exp;
    logic [4:0]  rop;
    logic [31:0] ra, rb;

    idle();
    clear = 1'b1;
    inport_data = '0;
    mem_overide = 1'b0;
    overide_address = '0;
    overide_data_in = '0;
    #3;
    check("reset_outport", outport_data, 0);
    check("reset_con", con_ff_bit, 0);
    check("reset_mar", MAR_address_out, 0);
    check("reset_mdr_out", Mem_data_to_chip_out, 0);
    check("reset_mem_out", Mem_to_datapath_out, 0);

    mem_overide = 1'b1;
    preload(9'd0, 32'hB980_0000);
    preload(9'd1, 32'hB200_0000);
    mem_overide = 1'b0;
    @(negedge Clock);
    clear = 1'b0;

    // Fetch of mem[0]
    @(posedge Clock); #1;
    fetch_t0(); tick();
    check("fetch0_mar", MAR_address_out, 0);
    fetch_t1(); tick();
    check("fetch0_mdr", Mem_data_to_chip_out, 32'hB980_0000);
    MDRout = 1'b1; IRin = 1'b1; tick();
    check("fetch0_ir", dut.ir, 32'hB980_0000);
    PCout = 1'b1; outport_in = 1'b1; tick();
    check("fetch0_pc", outport_data, 1);

    // Fetch of mem[1]: in r4
    fetch_t0(); tick();
    check("fetch1_mar", MAR_address_out, 1);
    fetch_t1(); tick();
    MDRout = 1'b1; IRin = 1'b1; tick();
    check("fetch1_ir", dut.ir, 32'hB200_0000);

    CONin = 1'b1; tick();
    check("con_eq0", con_ff_bit, 1);

    drive_bus(32'h1234_5678); Gra = 1'b1; Rin = 1'b1; tick();
    Gra = 1'b1; Rout = 1'b1; outport_in = 1'b1; tick();
    check("out_r4", outport_data, 32'h1234_5678);

    // CON conditions 01 and 11
    load_ir(32'h0008_0000);
    drive_bus(32'h0000_0000); CONin = 1'b1; tick();
    check("con_ne0_zero", con_ff_bit, 0);
    load_ir(32'h0018_0000);
    drive_bus(32'h8000_0000); CONin = 1'b1; tick();
    check("con_neg", con_ff_bit, 1);
    drive_bus(32'h0000_0001); CONin = 1'b1; tick();
    check("con_neg_pos", con_ff_bit, 0);

    // R0 via BAout reads as 0, via Rout as stored
    load_ir(32'h0000_0000);
    drive_bus(32'hDEAD_BEEF); Gra = 1'b1; Rin = 1'b1; tick();
    Gra = 1'b1; BAout = 1'b1; outport_in = 1'b1; tick();
    check("baout_r0", outport_data, 0);
    Gra = 1'b1; Rout = 1'b1; outport_in = 1'b1; tick();
    check("rout_r0", outport_data, 32'hDEAD_BEEF);

    load_ir(32'h0004_0000);
    Cout = 1'b1; outport_in = 1'b1; tick();
    check("cout_sext", outport_data, 32'hFFFC_0000);

    drive_bus(32'hA5A5_0001); HIin = 1'b1; tick();
    HIout = 1'b1; outport_in = 1'b1; tick();
    check("hi_reg", outport_data, 32'hA5A5_0001);

    // Normal memory write then read
    drive_bus(32'd5); MARin = 1'b1; tick();
    drive_bus(32'hCAFE_F00D); MDRin = 1'b1; tick();
    Mem_Write = 1'b1; Mem_enable512x32 = 1'b1; tick();
    Mem_Read = 1'b1; Mem_enable512x32 = 1'b1; #1;
    check("mem_rw", Mem_to_datapath_out, 32'hCAFE_F00D);
    idle();

    vecs.push_back('{5'b00000, 32'd5,          32'd7,          32'd0, 32'd12});
    vecs.push_back('{5'b00011, 32'hFFFF_FFFF,  32'd1,          32'd0, 32'd0});
    vecs.push_back('{5'b01100, 32'd100,        32'd23,         32'd0, 32'd123});
    vecs.push_back('{5'b00100, 32'd3,          32'd5,          32'd0, 32'hFFFF_FFFE});
    vecs.push_back('{5'b00101, 32'hF0F0,       32'hFF00,       32'd0, 32'hF000});
    vecs.push_back('{5'b01110, 32'hF0F0,       32'h0F0F,       32'd0, 32'hFFFF});
    vecs.push_back('{5'b00111, 32'h8000_0000,  32'd4,          32'd0, 32'h0800_0000});
    vecs.push_back('{5'b01000, 32'h8000_0000,  32'd4,          32'd0, 32'hF800_0000});
    vecs.push_back('{5'b01001, 32'd1,          32'd31,         32'd0, 32'h8000_0000});
    vecs.push_back('{5'b01010, 32'd1,          32'd1,          32'd0, 32'h8000_0000});
    vecs.push_back('{5'b01011, 32'h8000_0000,  32'd1,          32'd0, 32'd1});
    vecs.push_back('{5'b01001, 32'h0000_00FF,  32'h0000_0024,  32'd0, 32'h0000_0FF0});
    vecs.push_back('{5'b10001, 32'd9,          32'd1,          32'd0, 32'hFFFF_FFFF});
    vecs.push_back('{5'b10010, 32'd9,          32'd0,          32'd0, 32'hFFFF_FFFF});
    vecs.push_back('{5'b10011, 32'd9,          32'h1234,       32'd0, 32'h1234});
`ifdef SYSTEM_MULDIV_EN
    vecs.push_back('{5'b01111, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFE});
    vecs.push_back('{5'b10000, 32'd7,          32'd2,          32'd1, 32'd3});
`else
    vecs.push_back('{5'b01111, 32'hFFFF_FFFF,  32'd2,          32'd0, 32'd0});
    vecs.push_back('{5'b10000, 32'd7,          32'd2,          32'd0, 32'd0});
`endif
    vecs.push_back('{5'b10000, 32'd7,          32'd0,          32'd0, 32'd0});

    foreach (vecs[i]) begin
      alu_run(vecs[i].op, vecs[i].a, vecs[i].b, hi, lo);
      check($sformatf("alu_vec%0d_lo", i), lo, vecs[i].lo);
      check($sformatf("alu_vec%0d_hi", i), hi, vecs[i].hi);
    end

    for (int k = 0; k < 40; k++) begin
      rop = 5'($urandom_range(0, 20));
      ra  = $urandom();
      rb  = $urandom();
      if (rop == 5'd16 && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
      exp = alu_model(rop, ra, rb);
      alu_run(rop, ra, rb, hi, lo);
      check($sformatf("alu_rnd%0d_op%0d_lo", k, rop), lo, exp[31:0]);
      check($sformatf("alu_rnd%0d_op%0d_hi", k, rop), hi, exp[63:32]);
    end

    // Clear mid-fetch
    drive_bus(32'd0); CONin = 1'b1; outport_in = 1'b1; tick();
    drive_bus(32'h0000_0077); outport_in = 1'b1; tick();
    load_ir(32'h0000_0000);
    drive_bus(32'd0); CONin = 1'b1; tick();
    check("pre_clear_con", con_ff_bit, 1);
    fetch_t0(); tick();
    fetch_t1();
    #2 clear = 1'b1;
    #1;
    check("clear_outport", outport_data, 0);
    check("clear_con", con_ff_bit, 0);
    check("clear_mar", MAR_address_out, 0);
    check("clear_mdr_out", Mem_data_to_chip_out, 0);
    check("clear_mem_out", Mem_to_datapath_out, 0);
    check("clear_pc", dut.pc, 0);
    idle();
    @(negedge Clock);
    clear = 1'b0;
    @(posedge Clock); #1;
    Mem_Read = 1'b1; Mem_enable512x32 = 1'b1; #1;
    check("mem0_retained", Mem_to_datapath_out, 32'hB980_0000);
    idle();
    drive_bus(32'd5); MARin = 1'b1; tick();
    Mem_Read = 1'b1; Mem_enable512x32 = 1'b1; #1;
    check("mem5_retained", Mem_to_datapath_out, 32'hCAFE_F00D);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
